exc_ctrl: RTL
=============

# exc_ctrl

Exception/return controller for the multi-cycle MIPS core: detects synchronous exceptions and external interrupts at commit, drives the write side of the EPC register on entry, and on ERET reads EPC back to redirect fetch. It owns the Status/Cause state (CP0 subset) and the one-cycle entry/return redirect and flush pulses consumed by the PC and pipeline control logic.

## Interface
- HANDLER_ADDR, 32'h0000_0800, fixed exception vector
- NUM_IRQ, 6, number of external interrupt lines (1..8)

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- pc_cur  in  32  PC of instruction at commit
- exc_ovf  in  1  arithmetic overflow on current instruction
- exc_ri  in  1  reserved instruction
- exc_sys  in  1  SYSCALL
- eret  in  1  current instruction is ERET
- irq  in  NUM_IRQ  external interrupts, asynchronous, level
- mtc0_we  in  1  write Status from mtc0_data
- mtc0_data  in  32  Status write data
- epc_val  in  32  current EPC register contents
- epc_we  out  1  EPC write strobe
- epc_din  out  32  value to store in EPC
- redirect  out  1  load PC from redirect_pc this cycle
- redirect_pc  out  32  redirect target
- flush  out  1  squash in-flight instruction
- status  out  32  bit0 IE, bit1 EXL, bits[8+NUM_IRQ-1:8] IM, others 0
- cause  out  32  bits[6:2] ExcCode, bits[8+NUM_IRQ-1:8] IP, others 0

## Operation
- irq passes a 2-flop synchronizer; IP field = synchronized irq (live, read-only).
- States: RUN (EXL=0), ENTER, HNDL (EXL=1), RET, FAULT.
- RUN: request priority exc_ovf (ExcCode 12) > exc_ri (10) > exc_sys (8) > interrupt (0). ERET in RUN is treated as exc_ri (ExcCode 10). Interrupt pending = IE & |(IP & IM). Any request -> ENTER; at that edge capture epc_din<=pc_cur, ExcCode, set EXL.
- ENTER (1 cycle): epc_we=1, redirect=1, redirect_pc=HANDLER_ADDR, flush=1 -> HNDL.
- HNDL: interrupts masked. eret (and no sync exception) -> RET. Any sync exception -> FAULT (ExcCode updated, EPC not written).
- RET (1 cycle): redirect=1, redirect_pc=epc_val, flush=1; EXL cleared at end of cycle -> RUN.
- FAULT: flush held 1, redirect 0; exit only by rst.
- mtc0_we in RUN/HNDL writes IE and IM only (EXL not software-writable); ignored in ENTER/RET/FAULT. Same-cycle mtc0 and exception entry: IE/IM take mtc0_data, EXL/ExcCode from entry.
- Sync exception and eret same cycle: exception wins.

## Timing
- All outputs registered or decoded from registered state; no combinational path inputs->outputs.
- Reset: state RUN, status=0, cause=0 (IP flops 0), epc_we=0, epc_din=0, redirect=0, redirect_pc=0, flush=0.
- Sync exception sampled at edge N -> ENTER during cycle N+1; EPC captures at edge N+2.
- irq rise: ENTER 3 cycles after first sampling edge (2 sync + 1 decision).
- ERET sampled at edge N -> RET during cycle N+1; status[1]=0 from edge N+2.
- rst mid-ENTER/RET: outputs to reset values immediately, epc_we pulse aborted.

## Configuration
- EXC_IRQ_EN defined: synchronizer, IP/IM fields and interrupt entry present.
- Undefined: irq ignored, IP and IM read 0, mtc0 writes IE only; only synchronous exceptions enter.

## Test plan
- exc_ovf=1, pc_cur=0x100 in RUN -> next cycle epc_we=1, epc_din=0x100, redirect_pc=0x800, flush=1; then cause[6:2]=12, status[1]=1.
- In HNDL, epc_val=0x104, eret=1 -> next cycle redirect=1, redirect_pc=0x104; following cycle status[1]=0, state RUN.
- status=0x401, irq[2] rises -> ENTER 3 cycles later, cause[6:2]=0, cause[10]=1; with status=0x001 no entry.
- exc_ovf, exc_sys, irq all asserted same cycle -> ExcCode 12, single ENTER pulse.
- exc_sys in HNDL -> flush=1 held indefinitely, epc_we stays 0, until rst.
- rst asserted during ENTER -> epc_we, redirect, flush, status, cause all 0 same cycle.

Source files
------------

// File: rtl/exc_ctrl.sv
// exc_ctrl: exception/return controller (CP0 Status/Cause subset) for the
// multi-cycle MIPS core. Detects synchronous exceptions and interrupts at
// commit, drives the EPC write side on entry and redirects fetch on ERET.
// Build option: define EXC_IRQ_EN to include the irq synchronizer, the IP/IM
// fields and interrupt entry; without it only synchronous exceptions enter.
module exc_ctrl #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0800,
    parameter int unsigned NUM_IRQ      = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        pc_cur,
    input  logic               exc_ovf,
    input  logic               exc_ri,
    input  logic               exc_sys,
    input  logic               eret,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               mtc0_we,
    input  logic [31:0]        mtc0_data,
    input  logic [31:0]        epc_val,
    output logic               epc_we,
    output logic [31:0]        epc_din,
    output logic               redirect,
    output logic [31:0]        redirect_pc,
    output logic               flush,
    output logic [31:0]        status,
    output logic [31:0]        cause
);

    typedef enum logic [2:0] {
        S_RUN,
        S_ENTER,
        S_HNDL,
        S_RET,
        S_FAULT
    } state_t;

    state_t             state;
    logic               ie;
    logic               exl;
    logic [4:0]         exc_code;
    logic [NUM_IRQ-1:0] im;
    logic [NUM_IRQ-1:0] ip;
    logic               irq_pend;
    logic               sync_exc;
    logic [4:0]         sync_code;
    logic [4:0]         run_code;
    logic               run_req;

    // Only a few Status bits are writable; the rest of the data bus is dropped.
    logic unused_inputs;
    assign unused_inputs = ^{mtc0_data, irq};

`ifdef EXC_IRQ_EN
    logic [NUM_IRQ-1:0] irq_meta;

    // Two-flop synchronizer for the asynchronous level interrupt lines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_meta <= '0;
            ip       <= '0;
        end else begin
            irq_meta <= irq;
            ip       <= irq_meta;
        end
    end

    assign irq_pend = ie & (|(ip & im));
`else
    assign ip       = '0;
    assign im       = '0;
    assign irq_pend = 1'b0;
`endif

    // Request decode: overflow > reserved instr > syscall > ERET-in-RUN > interrupt.
    always_comb begin
        sync_exc  = exc_ovf | exc_ri | exc_sys;
        sync_code = 5'd8;
        if (exc_ovf)     sync_code = 5'd12;
        else if (exc_ri) sync_code = 5'd10;
        run_code = 5'd0;
        if (sync_exc)  run_code = sync_code;
        else if (eret) run_code = 5'd10;
        run_req = sync_exc | eret | irq_pend;
    end

    // Controller FSM with registered strobes and CP0 state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_RUN;
            ie          <= 1'b0;
            exl         <= 1'b0;
            exc_code    <= '0;
            epc_we      <= 1'b0;
            epc_din     <= '0;
            redirect    <= 1'b0;
            redirect_pc <= '0;
            flush       <= 1'b0;
`ifdef EXC_IRQ_EN
            im          <= '0;
`endif
        end else begin
            epc_we   <= 1'b0;
            redirect <= 1'b0;
            flush    <= 1'b0;
            // Software Status write shares the cycle with any entry; entry only
            // touches EXL/ExcCode so both updates land together.
            if (mtc0_we && (state == S_RUN || state == S_HNDL)) begin
                ie <= mtc0_data[0];
`ifdef EXC_IRQ_EN
                im <= mtc0_data[8 +: NUM_IRQ];
`endif
            end
            case (state)
                S_RUN: begin
                    if (run_req) begin
                        state       <= S_ENTER;
                        exl         <= 1'b1;
                        exc_code    <= run_code;
                        epc_we      <= 1'b1;
                        epc_din     <= pc_cur;
                        redirect    <= 1'b1;
                        redirect_pc <= HANDLER_ADDR;
                        flush       <= 1'b1;
                    end
                end
                S_ENTER: begin
                    state <= S_HNDL;
                end
                S_HNDL: begin
                    if (sync_exc) begin
                        state    <= S_FAULT;
                        exc_code <= sync_code;
                        flush    <= 1'b1;
                    end else if (eret) begin
                        state       <= S_RET;
                        redirect    <= 1'b1;
                        redirect_pc <= epc_val;
                        flush       <= 1'b1;
                    end
                end
                S_RET: begin
                    state <= S_RUN;
                    exl   <= 1'b0;
                end
                S_FAULT: begin
                    flush <= 1'b1;
                end
                default: begin
                    state <= S_FAULT;
                    flush <= 1'b1;
                end
            endcase
        end
    end

    // Status/Cause views assembled from registered state.
    always_comb begin
        status              = '0;
        status[0]           = ie;
        status[1]           = exl;
        status[8 +: NUM_IRQ] = im;
        cause               = '0;
        cause[6:2]          = exc_code;
        cause[8 +: NUM_IRQ] = ip;
    end

endmodule
